// File: rtl/muldiv_unit_if.sv
// Pipeline-side bundle for the multiply/divide unit: issue, HI/LO access and status.
interface muldiv_unit_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        rd_hi;
   logic        rd_lo;
   logic        wr_hi;
   logic        wr_lo;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        stall;

   modport master (
      output start, op, rs_data, rt_data, rd_hi, rd_lo, wr_hi, wr_lo,
      input  hi, lo, busy, done, stall
   );

   modport slave (
      input  start, op, rs_data, rt_data, rd_hi, rd_lo, wr_hi, wr_lo,
      output hi, lo, busy, done, stall
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning HI/LO: 32 shift-add or
// restoring-divide iterations on unsigned magnitudes, then a sign-fix cycle.
module muldiv_unit (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic        busy_q;
   logic        done_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   logic        is_div_q;
   logic        neg_res_q;
   logic        neg_rem_q;
   logic        dbz_q;
   logic [31:0] rs_orig_q;
   logic [31:0] fix_op_q;   // multiplicand (mult) or divisor (div), constant during RUN
   logic [31:0] shf_q;      // multiplier shifting right, or dividend shifting into quotient
   logic [31:0] shf_d;
   logic [63:0] acc_q;
   logic [63:0] acc_d;
   logic [32:0] rem_q;
   logic [32:0] rem_d;

   logic [32:0] sum;
   logic [32:0] shifted;
   logic [33:0] diff;
   logic [63:0] prod_fix;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        signed_op;

   function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
      return (sgn && x[31]) ? (~x + 32'd1) : x;
   endfunction

   function automatic logic [31:0] neg32(input logic [31:0] x, input logic en);
      return en ? (~x + 32'd1) : x;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] x, input logic en);
      return en ? (~x + 64'd1) : x;
   endfunction

   assign signed_op = ~bus.op[0];

   // One iteration of either sequence
   always_comb begin
      acc_d   = acc_q;
      rem_d   = rem_q;
      shf_d   = shf_q;
      sum     = '0;
      shifted = '0;
      diff    = '0;
      if (is_div_q) begin
         shifted = {rem_q[31:0], shf_q[31]};
         diff    = {1'b0, shifted} - {2'b00, fix_op_q};
         if (!diff[33]) begin
            rem_d = diff[32:0];
            shf_d = {shf_q[30:0], 1'b1};
         end else begin
            rem_d = shifted;
            shf_d = {shf_q[30:0], 1'b0};
         end
      end else begin
         sum   = {1'b0, acc_q[63:32]} + (shf_q[0] ? {1'b0, fix_op_q} : 33'd0);
         acc_d = {sum, acc_q[31:1]};
         shf_d = {1'b0, shf_q[31:1]};
      end
   end

   // Sign fix-up and special divide cases applied in FIX
   always_comb begin
      prod_fix = neg64(acc_q, neg_res_q);
      res_hi   = prod_fix[63:32];
      res_lo   = prod_fix[31:0];
      if (is_div_q) begin
         if (dbz_q) begin
            res_hi = rs_orig_q;
            res_lo = 32'hFFFF_FFFF;
         end else begin
            res_hi = neg32(rem_q[31:0], neg_rem_q);
            res_lo = neg32(shf_q, neg_res_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  cnt_q   <= 5'd0;
               end else begin
                  if (bus.wr_hi) hi_q <= bus.rs_data;
                  if (bus.wr_lo) lo_q <= bus.rs_data;
               end
            end
            RUN: begin
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= FIX;
            end
            FIX: begin
               hi_q    <= res_hi;
               lo_q    <= res_lo;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Operand latch at issue, iteration registers during RUN
   always_ff @(posedge clk) begin
      if (state_q == IDLE && bus.start) begin
         is_div_q  <= bus.op[1];
         neg_res_q <= signed_op & (bus.rs_data[31] ^ bus.rt_data[31]);
         neg_rem_q <= signed_op & bus.rs_data[31];
         dbz_q     <= bus.op[1] & (bus.rt_data == 32'd0);
         rs_orig_q <= bus.rs_data;
         acc_q     <= 64'd0;
         rem_q     <= 33'd0;
         if (bus.op[1]) begin
            fix_op_q <= mag32(bus.rt_data, signed_op);
            shf_q    <= mag32(bus.rs_data, signed_op);
         end else begin
            fix_op_q <= mag32(bus.rs_data, signed_op);
            shf_q    <= mag32(bus.rt_data, signed_op);
         end
      end else if (state_q == RUN) begin
         acc_q <= acc_d;
         rem_q <= rem_d;
         shf_q <= shf_d;
      end
   end

   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.stall = busy_q & (bus.start | bus.rd_hi | bus.rd_lo | bus.wr_hi | bus.wr_lo);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed literal checks plus randomized traffic against a cycle-level reference.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   muldiv_unit_if bus();
   muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   bit          m_busy, m_done;
   int          m_left;

   // Architectural result of one operation
   task automatic ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl);
      logic [63:0] p;
      p  = 64'd0;
      rh = 32'd0;
      rl = 32'd0;
      case (op)
         2'b00: begin p = longint'($signed(a)) * longint'($signed(b)); rh = p[63:32]; rl = p[31:0]; end
         2'b01: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
         2'b10: begin
            if (b == 32'd0) begin rl = 32'hFFFF_FFFF; rh = a; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rl = 32'h8000_0000; rh = 32'd0; end
            else begin rl = 32'($signed(a) / $signed(b)); rh = 32'($signed(a) % $signed(b)); end
         end
         default: begin
            if (b == 32'd0) begin rl = 32'hFFFF_FFFF; rh = a; end
            else begin rl = a / b; rh = a % b; end
         end
      endcase
   endtask

   // Reference: 33 busy cycles after the start edge, result lands with done
   always @(posedge clk) begin
      if (rst) begin
         m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; m_left = 0;
      end else begin
         m_done = 0;
         if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_busy = 0; m_done = 1; m_hi = p_hi; m_lo = p_lo;
            end
         end else if (bus.start) begin
            ref_op(bus.op, bus.rs_data, bus.rt_data, p_hi, p_lo);
            m_busy = 1;
            m_left = 33;
         end else begin
            if (bus.wr_hi) m_hi = bus.rs_data;
            if (bus.wr_lo) m_lo = bus.rs_data;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_stall;
         exp_stall = m_busy & (bus.start | bus.rd_hi | bus.rd_lo | bus.wr_hi | bus.wr_lo);
         n_vec++;
         if (bus.hi !== m_hi || bus.lo !== m_lo || bus.busy !== m_busy ||
             bus.done !== m_done || bus.stall !== exp_stall) begin
            n_err++;
            $display("FAIL cycle t=%0t: hi=%h lo=%h busy=%b done=%b stall=%b, required hi=%h lo=%h busy=%b done=%b stall=%b",
                     $time, bus.hi, bus.lo, bus.busy, bus.done, bus.stall,
                     m_hi, m_lo, m_busy, m_done, exp_stall);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #2;
      bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
      @(posedge clk); #2;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int nbusy);
      bit seen;
      seen  = 0;
      nbusy = 0;
      for (int i = 0; i < 45 && !seen; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) nbusy++;
         if (bus.done === 1'b1) seen = 1;
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      int nb;
      issue(op, a, b);
      wait_done(nb);
      chk({nm, "_hi"}, bus.hi, eh);
      chk({nm, "_lo"}, bus.lo, el);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int nb, ndone;
      bus.start = 0; bus.op = 0; bus.rs_data = 0; bus.rt_data = 0;
      bus.rd_hi = 0; bus.rd_lo = 0; bus.wr_hi = 0; bus.wr_lo = 0;

      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_hi", bus.hi, 32'd0);
      chk("rst_lo", bus.lo, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);

      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(nb);
      chk("multu_busy_cycles", nb, 32'd33);
      chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
      chk("multu_lo", bus.lo, 32'h0000_0001);
      @(negedge clk);
      chk("multu_done_one_cycle", {31'd0, bus.done}, 32'd0);

      run_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
      run_op("div_zero_s", 2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
      run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);

      // Requests while busy must stall and be ignored
      issue(2'b11, 32'd100, 32'd7);
      repeat (4) @(posedge clk);
      #2 bus.rd_lo = 1'b1;
      @(negedge clk);
      chk("stall_rd_lo", {31'd0, bus.stall}, 32'd1);
      chk("lo_held_busy", bus.lo, 32'hFFFF_FFFF);
      @(posedge clk); #2 bus.rd_lo = 1'b0;
      repeat (4) @(posedge clk);
      #2 bus.start = 1'b1; bus.op = 2'b01; bus.rs_data = 32'd5; bus.rt_data = 32'd5;
      @(negedge clk);
      chk("stall_start", {31'd0, bus.stall}, 32'd1);
      @(posedge clk); #2 bus.start = 1'b0;
      wait_done(nb);
      chk("divu_100d7_lo", bus.lo, 32'd14);
      chk("divu_100d7_hi", bus.hi, 32'd2);
      repeat (3) @(negedge clk);
      chk("second_start_ignored", {31'd0, bus.busy}, 32'd0);

      // MTHI in idle, then start+MTLO together
      @(posedge clk); #2 bus.wr_hi = 1'b1; bus.rs_data = 32'h1234_5678;
      @(negedge clk);
      chk("idle_no_stall", {31'd0, bus.stall}, 32'd0);
      @(posedge clk); #2 bus.wr_hi = 1'b0;
      @(negedge clk);
      chk("mthi", bus.hi, 32'h1234_5678);
      @(posedge clk); #2;
      bus.start = 1'b1; bus.wr_lo = 1'b1; bus.op = 2'b01; bus.rs_data = 32'hAAAA_AAAA; bus.rt_data = 32'd2;
      @(posedge clk); #2 bus.start = 1'b0; bus.wr_lo = 1'b0;
      @(negedge clk);
      chk("start_wins_lo", bus.lo, 32'd14);
      chk("start_wins_busy", {31'd0, bus.busy}, 32'd1);
      wait_done(nb);
      chk("multu_aa_hi", bus.hi, 32'd1);
      chk("multu_aa_lo", bus.lo, 32'h5555_5554);

      // Reset in the middle of an operation
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_hi", bus.hi, 32'd0);
      chk("midrst_lo", bus.lo, 32'd0);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      chk("midrst_no_done", ndone, 32'd0);

      // Randomized traffic, checked every cycle against the reference
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #2;
         bus.start   = ($urandom_range(0, 5) == 0);
         bus.op      = 2'($urandom_range(0, 3));
         bus.rs_data = pick();
         bus.rt_data = pick();
         bus.rd_hi   = ($urandom_range(0, 7) == 0);
         bus.rd_lo   = ($urandom_range(0, 7) == 0);
         bus.wr_hi   = ($urandom_range(0, 9) == 0);
         bus.wr_lo   = ($urandom_range(0, 9) == 0);
      end
      @(posedge clk); #2;
      bus.start = 0; bus.rd_hi = 0; bus.rd_lo = 0; bus.wr_hi = 0; bus.wr_lo = 0;
      for (int i = 0; i < 60 && m_busy; i++) @(negedge clk);
      chk("drain_idle", {31'd0, bus.busy}, 32'd0);
      repeat (2) @(negedge clk);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
